// File: rtl/difftest_delayed_wb_tracker.sv
// Tracks committed destinations with deferred values and emits ordered difftest delayed-wb events.
// Optional sticky error tracking is enabled by defining DIFFTEST_DELAYED_CHECK_EN.
module difftest_delayed_wb_tracker #(
  parameter int unsigned TAG_W      = 2,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [7:0]  CORE_ID    = 8'd0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             commit_valid,
  input  logic [4:0]       commit_rd,
  input  logic [TAG_W-1:0] commit_tag,
  input  logic             wb_valid,
  input  logic [TAG_W-1:0] wb_tag,
  input  logic [63:0]      wb_data,
  input  logic             wb_kill,
  output logic             enable,
  output logic             io_valid,
  output logic [4:0]       io_address,
  output logic [63:0]      io_data,
  output logic             io_nack,
  output logic [7:0]       io_coreid,
  output logic [7:0]       io_index
`ifdef DIFFTEST_DELAYED_CHECK_EN
  ,
  output logic [2:0]       err
`endif
);

  localparam int unsigned NumTags = 1 << TAG_W;
  localparam int unsigned PtrW    = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [4:0]  rd;
    logic [63:0] data;
    logic        nack;
  } event_t;

  logic [NumTags-1:0] vld_q, vld_d;
  logic [4:0]         rd_tbl_q [NumTags];
  logic               tbl_we;

  event_t             fifo_q [FIFO_DEPTH];
  logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]      count_q, count_d;
  logic [7:0]         idx_q;

  event_t             ev, head;
  logic               push, enq, deq, full;
  logic               bypass, orphan, dup, overflow;

  always_comb begin
    vld_d  = vld_q;
    tbl_we = 1'b0;
    push   = 1'b0;
    ev     = '0;
    orphan = 1'b0;
    dup    = 1'b0;
    bypass = commit_valid && wb_valid && (commit_tag == wb_tag);

    if (bypass) begin
      // Value arrives with the commit: never enters the table.
      vld_d[wb_tag] = 1'b0;
      orphan        = wb_kill;
      if (commit_rd != 5'd0) begin
        push = 1'b1;
        ev   = '{rd: commit_rd, data: wb_data, nack: 1'b0};
      end
    end else begin
      if (wb_valid || wb_kill) begin
        if (wb_valid && wb_kill) orphan = 1'b1;
        if (vld_q[wb_tag]) begin
          push          = 1'b1;
          ev            = '{rd: rd_tbl_q[wb_tag], data: wb_valid ? wb_data : 64'd0,
                            nack: !wb_valid};
          vld_d[wb_tag] = 1'b0;
        end else begin
          orphan = 1'b1;
        end
      end
      if (commit_valid && (commit_rd != 5'd0)) begin
        // vld_d already reflects a same-cycle completion of the old holder.
        dup               = vld_d[commit_tag];
        vld_d[commit_tag] = 1'b1;
        tbl_we            = 1'b1;
      end
    end
  end

  // The sink never stalls, so the head leaves every cycle the queue is non-empty.
  assign deq      = (count_q != '0);
  assign full     = (count_q == (PtrW + 1)'(FIFO_DEPTH));
  assign enq      = push && (!full || deq);
  assign overflow = push && full && !deq;

  always_comb begin
    count_d = count_q;
    unique case ({enq, deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      idx_q    <= 8'd0;
    end else begin
      vld_q   <= vld_d;
      count_q <= count_d;
      if (enq) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (deq) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        idx_q    <= idx_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (tbl_we) rd_tbl_q[commit_tag] <= commit_rd;
    if (enq)    fifo_q[wr_ptr_q]     <= ev;
  end

  always_comb begin
    head       = fifo_q[rd_ptr_q];
    io_valid   = deq;
    enable     = deq;
    io_address = deq ? head.rd : 5'd0;
    io_data    = deq ? head.data : 64'd0;
    io_nack    = deq && head.nack;
    io_coreid  = CORE_ID;
    io_index   = idx_q;
  end

`ifdef DIFFTEST_DELAYED_CHECK_EN
  logic [2:0] err_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) err_q <= 3'b000;
    else          err_q <= err_q | {overflow, orphan, dup};
  end

  assign err = err_q;

`ifndef SYNTHESIS
  always @(posedge clock) begin
    if (reset_n) begin
      if (overflow && !err_q[2]) $error("delayed wb tracker: event queue overflow");
      if (orphan && !err_q[1])   $error("delayed wb tracker: orphan writeback/kill");
      if (dup && !err_q[0])      $error("delayed wb tracker: duplicate commit to pending tag");
    end
  end
`endif
`else
  logic unused_err;
  assign unused_err = ^{overflow, orphan, dup};
`endif

endmodule

// File: tb/tb_difftest_delayed_wb_tracker.sv
// Scoreboard bench: a table-level reference model predicts each event; a monitor checks the sink.
module tb_difftest_delayed_wb_tracker;

  logic        clock;
  logic        reset_n;
  logic        commit_valid;
  logic [4:0]  commit_rd;
  logic [1:0]  commit_tag;
  logic        wb_valid;
  logic [1:0]  wb_tag;
  logic [63:0] wb_data;
  logic        wb_kill;
  logic        enable, io_valid, io_nack;
  logic [4:0]  io_address;
  logic [63:0] io_data;
  logic [7:0]  io_coreid, io_index;
`ifdef DIFFTEST_DELAYED_CHECK_EN
  logic [2:0]  err;
`endif

  difftest_delayed_wb_tracker #(
    .TAG_W      (2),
    .FIFO_DEPTH (4),
    .CORE_ID    (8'hA5)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .commit_valid (commit_valid),
    .commit_rd    (commit_rd),
    .commit_tag   (commit_tag),
    .wb_valid     (wb_valid),
    .wb_tag       (wb_tag),
    .wb_data      (wb_data),
    .wb_kill      (wb_kill),
    .enable       (enable),
    .io_valid     (io_valid),
    .io_address   (io_address),
    .io_data      (io_data),
    .io_nack      (io_nack),
    .io_coreid    (io_coreid),
`ifdef DIFFTEST_DELAYED_CHECK_EN
    .io_index     (io_index),
    .err          (err)
`else
    .io_index     (io_index)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct {
    logic [4:0]  a;
    logic [63:0] d;
    logic        n;
    logic [7:0]  idx;
    int          due;
  } exp_t;

  exp_t       sb[$];
  bit         m_pending [4];
  logic [4:0] m_rd [4];
  int         m_count;
  int         m_last_due;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_pending[i] = 0;
    m_count    = 0;
    m_last_due = 0;
    sb.delete();
  endtask

  // Applies this cycle's inputs to the reference table and predicts the resulting event.
  task automatic model_step();
    bit          has_ev = 0;
    exp_t        e;
    if (commit_valid && wb_valid && commit_tag == wb_tag) begin
      m_pending[wb_tag] = 0;
      if (commit_rd != 0) begin
        has_ev = 1; e.a = commit_rd; e.d = wb_data; e.n = 0;
      end
    end else begin
      if ((wb_valid || wb_kill) && m_pending[wb_tag]) begin
        has_ev = 1;
        e.a    = m_rd[wb_tag];
        e.d    = wb_valid ? wb_data : 64'd0;
        e.n    = !wb_valid;
        m_pending[wb_tag] = 0;
      end
      if (commit_valid && commit_rd != 0) begin
        m_pending[commit_tag] = 1;
        m_rd[commit_tag]      = commit_rd;
      end
    end
    if (has_ev) begin
      e.idx      = 8'(m_count % 256);
      e.due      = (cyc + 1 > m_last_due + 1) ? cyc + 1 : m_last_due + 1;
      m_last_due = e.due;
      m_count++;
      sb.push_back(e);
    end
  endtask

  task automatic drive(input logic cv, input logic [4:0] rd, input logic [1:0] ct,
                       input logic wv, input logic [1:0] wt, input logic [63:0] d,
                       input logic k);
    @(posedge clock);
    #1;
    commit_valid = cv; commit_rd = rd; commit_tag = ct;
    wb_valid = wv; wb_tag = wt; wb_data = d; wb_kill = k;
    model_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 5'd0, 2'd0, 0, 2'd0, 64'd0, 0);
  endtask

  bit   mon_en = 0;
  logic exp_v;
  exp_t got;

  always @(negedge clock) begin
    if (mon_en) begin
      exp_v = (sb.size() > 0) && (sb[0].due == cyc);
      chk("io_valid", io_valid, exp_v);
      chk("enable", enable, exp_v);
      if (io_valid && exp_v) begin
        got = sb.pop_front();
        chk("event{addr,data,nack,index}", {io_address, io_data, io_nack, io_index},
            {got.a, got.d, got.n, got.idx});
        chk("io_coreid", io_coreid, 8'hA5);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    reset_n = 0;
    commit_valid = 0; commit_rd = 0; commit_tag = 0;
    wb_valid = 0; wb_tag = 0; wb_data = 0; wb_kill = 0;
    model_reset();
    repeat (3) @(negedge clock);
    chk("reset_outputs", {enable, io_valid, io_address, io_data, io_nack, io_index},
        {1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 8'd0});
    reset_n = 1;
    mon_en  = 1;

    // Deferred load completes three cycles after commit.
    drive(1, 5'd5, 2'd1, 0, 2'd0, 64'd0, 0);
    idle(2);
    drive(0, 5'd0, 2'd0, 1, 2'd1, 64'hDEAD_BEEF, 0);
    idle(2);

    // Kill produces a nack; the later writeback is an orphan.
    drive(1, 5'd7, 2'd2, 0, 2'd0, 64'd0, 0);
    drive(0, 5'd0, 2'd2, 0, 2'd2, 64'd0, 1);
    drive(0, 5'd0, 2'd0, 1, 2'd2, 64'h1111, 0);
    idle(2);

    // Same-cycle bypass leaves tag 3 clear.
    drive(1, 5'd9, 2'd3, 1, 2'd3, 64'h42, 0);
    drive(0, 5'd0, 2'd0, 1, 2'd3, 64'h55, 0);
    idle(2);

    // rd 0 never produces an event.
    drive(1, 5'd0, 2'd0, 0, 2'd0, 64'd0, 0);
    drive(0, 5'd0, 2'd0, 1, 2'd0, 64'h77, 0);
    idle(2);

    // Four outstanding tags completed back-to-back.
    for (int t = 0; t < 4; t++) drive(1, 5'(10 + t), 2'(t), 0, 2'd0, 64'd0, 0);
    for (int t = 0; t < 4; t++) drive(0, 5'd0, 2'd0, 1, 2'(t), 64'(100 + t), 0);
    idle(2);

    // Enough back-to-back events to wrap the index.
    for (int i = 0; i < 260; i++)
      drive(1, 5'(1 + i % 31), 2'(i % 4), 1, 2'(i % 4), {$urandom, $urandom}, 0);
    idle(2);

    // Reset while an event is being presented.
    drive(1, 5'd3, 2'd0, 0, 2'd0, 64'd0, 0);
    drive(0, 5'd0, 2'd0, 1, 2'd0, 64'h1234, 0);
    @(posedge clock);
    #1;
    chk("pre_reset_valid", io_valid, 1'b1);
    commit_valid = 0; wb_valid = 0; wb_kill = 0;
    reset_n = 0;
    model_reset();
    #1;
    chk("reset_drops_valid", {io_valid, io_index}, {1'b0, 8'd0});
    repeat (2) @(negedge clock);
    reset_n = 1;
    drive(1, 5'd4, 2'd2, 0, 2'd0, 64'd0, 0);
    drive(0, 5'd0, 2'd0, 1, 2'd2, 64'hCAFE, 0);
    idle(2);

    // Random traffic including kills, dups, orphans and overlaps.
    for (int i = 0; i < 600; i++)
      drive($urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
            $urandom_range(0, 9) < 4, 2'($urandom_range(0, 3)), {$urandom, $urandom},
            $urandom_range(0, 19) < 3);
    idle(4);

    chk("scoreboard_drained", 128'(sb.size()), 128'd0);
    mon_en = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
